ofc_capture_fifo: RTL and testbench

OFC_CAPTURE_FIFO -- requirements
Module: ofc_capture_fifo

---
 rtl/ofc_capture_fifo.sv | 69 ++++++
 tb/tb_ofc_capture_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ofc_capture_fifo.sv
// Capture FIFO for {o,f,c} result words. Optional per-entry even-parity
// checking is built when OFC_CAPTURE_PARITY_EN is defined.
module ofc_capture_fifo #(
    parameter int wd    = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [wd-1:0]            in_o,
    input  logic [wd-1:0]            in_f,
    input  logic [wd-1:0]            in_c,
    input  logic                     in_par,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3*wd-1:0]          out_data,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    ptr_t            wr_ptr, rd_ptr;
    logic [3*wd-1:0] mem [DEPTH];
    logic            push, pop;

    // Extra pointer MSB makes full (diff == DEPTH) distinct from empty (diff == 0).
    assign count     = wr_ptr - rd_ptr;
    assign in_ready  = (count != ptr_t'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= {in_o, in_f, in_c};
    end

`ifdef OFC_CAPTURE_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push && !flush) par_mem[wr_ptr[AW-1:0]] <= in_par;
    end

    assign out_err = out_valid && ((^out_data) != par_mem[rd_ptr[AW-1:0]]);
`else
    logic unused_par;
    assign unused_par = in_par;
    assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ofc_capture_fifo.sv
// Self-checking bench for ofc_capture_fifo: vector table, hand sequences for
// wrap/reset/parity corners, and randomized traffic against a queue model.
module tb_ofc_capture_fifo;
    localparam int WD    = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [WD-1:0]    in_o, in_f, in_c;
    logic             in_par, flush;
    logic             out_valid, out_ready, out_err;
    logic [3*WD-1:0]  out_data;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_err = 0;

    ofc_capture_fifo #(.wd(WD), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_o(in_o), .in_f(in_f), .in_c(in_c), .in_par(in_par), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [11:0] d;
        logic        ordy;
        logic        fl;
        int          cnt;
        logic        vld;
        logic        rdy;
        logic [11:0] exp_d;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after an edge; the next edge samples them.
    task automatic drive(input logic iv, input logic [11:0] d, input logic par,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        {in_o, in_f, in_c} = d;
        in_par    = par;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic exp_err(input logic [11:0] d, input logic par);
`ifdef OFC_CAPTURE_PARITY_EN
        return (^d) != par;
`else
        return 1'b0 & (^d) & par;
`endif
    endfunction

    // Behavioural model: a plain queue of {parity, data}.
    logic [12:0] mq[$];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //           iv  data   ordy fl  cnt vld rdy exp_d
        tbl[0]  = '{1'b1, 12'h5A3, 1'b0, 1'b0, 1, 1'b1, 1'b1, 12'h5A3};
        tbl[1]  = '{1'b1, 12'h111, 1'b0, 1'b0, 2, 1'b1, 1'b1, 12'h5A3};
        tbl[2]  = '{1'b1, 12'h222, 1'b0, 1'b0, 3, 1'b1, 1'b1, 12'h5A3};
        tbl[3]  = '{1'b1, 12'h333, 1'b0, 1'b0, 4, 1'b1, 1'b0, 12'h5A3};
        tbl[4]  = '{1'b1, 12'h444, 1'b0, 1'b0, 4, 1'b1, 1'b0, 12'h5A3};
        tbl[5]  = '{1'b1, 12'h444, 1'b1, 1'b0, 3, 1'b1, 1'b1, 12'h111};
        tbl[6]  = '{1'b0, 12'h000, 1'b1, 1'b0, 2, 1'b1, 1'b1, 12'h222};
        tbl[7]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1, 1'b1, 1'b1, 12'h333};
        tbl[8]  = '{1'b0, 12'h000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 12'h000};
        tbl[9]  = '{1'b0, 12'h000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 12'h000};
        tbl[10] = '{1'b1, 12'h0AB, 1'b0, 1'b0, 1, 1'b1, 1'b1, 12'h0AB};
        tbl[11] = '{1'b1, 12'h0CD, 1'b0, 1'b0, 2, 1'b1, 1'b1, 12'h0AB};
        tbl[12] = '{1'b1, 12'h0EF, 1'b0, 1'b0, 3, 1'b1, 1'b1, 12'h0AB};
        tbl[13] = '{1'b1, 12'h777, 1'b1, 1'b1, 0, 1'b0, 1'b1, 12'h000};
        tbl[14] = '{1'b1, 12'h888, 1'b0, 1'b0, 1, 1'b1, 1'b1, 12'h888};
        tbl[15] = '{1'b0, 12'h000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 12'h000};

        rst_n = 1'b0;
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_err", 32'(out_err), 0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].iv, tbl[i].d, ^tbl[i].d, tbl[i].ordy, tbl[i].fl);
            step();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            if (tbl[i].vld) chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].exp_d));
        end

        // Steady state at count=2 with push+pop every cycle; pointers wrap repeatedly.
        drive(1'b1, 12'hA00, ^12'hA00, 1'b0, 1'b0); step();
        drive(1'b1, 12'hA01, ^12'hA01, 1'b0, 1'b0); step();
        for (int i = 0; i < 10; i++) begin
            logic [11:0] w;
            w = 12'hA02 + 12'(i);
            drive(1'b1, w, ^w, 1'b1, 1'b0);
            step();
            chk($sformatf("steady%0d_count", i), 32'(count), 2);
            chk($sformatf("steady%0d_head", i), 32'(out_data), 32'(12'hA01 + 12'(i)));
        end
        drive(1'b0, 12'h000, 1'b0, 1'b1, 1'b0); step(); step();
        chk("steady_drain", 32'(count), 0);

        // Asynchronous reset pulse between edges with two entries held.
        drive(1'b1, 12'hB01, ^12'hB01, 1'b0, 1'b0); step();
        drive(1'b1, 12'hB02, ^12'hB02, 1'b0, 1'b0); step();
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        chk("pre_async_count", 32'(count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_count", 32'(count), 0);
        chk("async_ready", 32'(in_ready), 1);
        #1 rst_n = 1'b1;
        drive(1'b1, 12'h111, ^12'h111, 1'b0, 1'b0); step();
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        chk("post_async_data", 32'(out_data), 32'h111);
        chk("post_async_count", 32'(count), 1);

        // Parity: 0x001 with par=0 is bad, 0x003 with par=0 is good.
        do_reset();
        drive(1'b1, 12'h001, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        chk("par_bad_err", 32'(out_err), 32'(exp_err(12'h001, 1'b0)));
        drive(1'b1, 12'h003, 1'b0, 1'b1, 1'b0); step();
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        chk("par_good_data", 32'(out_data), 32'h003);
        chk("par_good_err", 32'(out_err), 32'(exp_err(12'h003, 1'b0)));

        // Randomized traffic against the queue model.
        do_reset();
        mq.delete();
        for (int i = 0; i < 400; i++) begin
            logic iv, ordy, fl, par, do_push, do_pop;
            logic [11:0] d;
            iv   = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 50);
            fl   = ($urandom_range(0, 99) < 3);
            d    = 12'($urandom);
            par  = ($urandom_range(0, 9) == 0) ? ~(^d) : ^d;
            drive(iv, d, par, ordy, fl);
            do_push = iv && (mq.size() != DEPTH);
            do_pop  = ordy && (mq.size() != 0);
            step();
            if (fl) mq.delete();
            else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back({par, d});
            end
            chk("rnd_count", 32'(count), 32'(mq.size()));
            chk("rnd_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("rnd_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
            if (mq.size() != 0) begin
                chk("rnd_data", 32'(out_data), 32'(mq[0][11:0]));
                chk("rnd_err", 32'(out_err), 32'(exp_err(mq[0][11:0], mq[0][12])));
            end else begin
                chk("rnd_err_empty", 32'(out_err), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
